// File: rtl/led_pkg.sv
// Shared constants and FSM state encoding for the LED mode scheduler.
package led_pkg;

  localparam int LED_W          = 8;

  localparam int MODE_BREATH    = 0;
  localparam int MODE_HEARTBEAT = 1;
  localparam int MODE_WATER     = 2;
  localparam int MODE_STATIC    = 3;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 240000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             accept_s;

  // A differing sample accepted on the DEBOUNCE_CYC-th consecutive occurrence
  always_comb begin
    if (sync_q[1] != level_q) begin
      accept_s = (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
    end else begin
      accept_s = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (accept_s) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        press_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// Mode sequencer for the LED effect drivers: button/auto-tick arbitration,
// blanking between modes, one-hot driver enables and the registered LED mux.
module led_mode_scheduler
  import led_pkg::*;
#(
  parameter int N_MODES      = 4,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int AUTO_PERIOD  = 120000000,
  parameter int BLANK_CYC    = 2400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_next,
  input  logic                       btn_prev,
  input  logic                       auto_en,
  input  logic [N_MODES*LED_W-1:0]   mode_led_in,
  output logic [LED_W-1:0]           led_out,
  output logic [N_MODES-1:0]         mode_en,
  output logic [$clog2(N_MODES)-1:0] mode_idx,
  output logic                       busy
);

  localparam int IDX_W   = $clog2(N_MODES);
  localparam int AUTO_W  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  function automatic logic [N_MODES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_MODES-1:0] v;
    v = '0;
    for (int k = 0; k < N_MODES; k++) begin
      v[k] = (idx == IDX_W'(k));
    end
    return v;
  endfunction

  state_t             state_q;
  logic [IDX_W-1:0]   mode_idx_q;
  logic [N_MODES-1:0] mode_en_q;
  logic [LED_W-1:0]   led_q;
  logic               busy_q;
  logic [AUTO_W-1:0]  auto_cnt_q;
  logic [AUTO_W-1:0]  auto_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q;

  logic               next_pulse_s;
  logic               prev_pulse_s;
  logic               tick_s;
  logic               switch_s;
  logic [IDX_W-1:0]   idx_inc_s;
  logic [IDX_W-1:0]   idx_dec_s;
  logic [IDX_W-1:0]   idx_d;
  logic [LED_W-1:0]   lane_s;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_next),
    .press_o (next_pulse_s)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_prev),
    .press_o (prev_pulse_s)
  );

  // Auto-advance timer only runs in RUN with auto_en set
  always_comb begin
    tick_s     = 1'b0;
    auto_cnt_d = '0;
    if ((state_q == ST_RUN) && auto_en) begin
      tick_s     = (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1));
      auto_cnt_d = tick_s ? '0 : auto_cnt_q + AUTO_W'(1);
    end else begin
      tick_s     = 1'b0;
      auto_cnt_d = '0;
    end
  end

  // Wrap by compare so non-power-of-two mode counts stay in range
  always_comb begin
    idx_inc_s = (mode_idx_q == IDX_W'(N_MODES - 1)) ? '0 : mode_idx_q + IDX_W'(1);
    idx_dec_s = (mode_idx_q == '0) ? IDX_W'(N_MODES - 1) : mode_idx_q - IDX_W'(1);
  end

  // Event arbitration: lone button beats tick, opposing buttons cancel
  always_comb begin
    switch_s = 1'b0;
    idx_d    = mode_idx_q;
    if (state_q != ST_RUN) begin
      switch_s = 1'b0;
    end else if (next_pulse_s && prev_pulse_s) begin
      switch_s = 1'b0;
    end else if (next_pulse_s) begin
      switch_s = 1'b1;
      idx_d    = idx_inc_s;
    end else if (prev_pulse_s) begin
      switch_s = 1'b1;
      idx_d    = idx_dec_s;
    end else if (tick_s) begin
      switch_s = 1'b1;
      idx_d    = idx_inc_s;
    end else begin
      switch_s = 1'b0;
    end
  end

  // AND-OR lane select keeps the index width independent of the bus width
  always_comb begin
    lane_s = '0;
    for (int k = 0; k < N_MODES; k++) begin
      lane_s = lane_s | (mode_led_in[k*LED_W +: LED_W] & {LED_W{mode_idx_q == IDX_W'(k)}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mode_idx_q  <= IDX_W'(MODE_BREATH);
      mode_en_q   <= onehot(IDX_W'(MODE_BREATH));
      led_q       <= '0;
      busy_q      <= 1'b0;
      auto_cnt_q  <= '0;
      blank_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (switch_s) begin
            state_q     <= ST_BLANK;
            mode_idx_q  <= idx_d;
            mode_en_q   <= '0;
            led_q       <= '0;
            busy_q      <= 1'b1;
            auto_cnt_q  <= '0;
            blank_cnt_q <= '0;
          end else begin
            mode_en_q   <= onehot(mode_idx_q);
            led_q       <= lane_s;
            busy_q      <= 1'b0;
            auto_cnt_q  <= auto_cnt_d;
            blank_cnt_q <= '0;
          end
        end
        ST_BLANK: begin
          led_q      <= '0;
          auto_cnt_q <= '0;
          if (blank_cnt_q == BLANK_W'(BLANK_CYC - 1)) begin
            state_q     <= ST_RUN;
            mode_en_q   <= onehot(mode_idx_q);
            busy_q      <= 1'b0;
            blank_cnt_q <= '0;
          end else begin
            mode_en_q   <= '0;
            busy_q      <= 1'b1;
            blank_cnt_q <= blank_cnt_q + BLANK_W'(1);
          end
        end
        default: begin
          state_q     <= ST_RUN;
          mode_idx_q  <= IDX_W'(MODE_BREATH);
          mode_en_q   <= onehot(IDX_W'(MODE_BREATH));
          led_q       <= '0;
          busy_q      <= 1'b0;
          auto_cnt_q  <= '0;
          blank_cnt_q <= '0;
        end
      endcase
    end
  end

  assign led_out  = led_q;
  assign mode_en  = mode_en_q;
  assign mode_idx = mode_idx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Scoreboard bench for led_mode_scheduler with short debounce/auto/blank timing.
module tb_led_mode_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        btn_prev;
  logic        auto_en;
  logic [31:0] mode_led_in;
  logic [7:0]  led_out;
  logic [3:0]  mode_en;
  logic [1:0]  mode_idx;
  logic        busy;

  always #5 clk = ~clk;

  led_mode_scheduler #(
    .N_MODES(4), .DEBOUNCE_CYC(4), .AUTO_PERIOD(50), .BLANK_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_en(auto_en), .mode_led_in(mode_led_in), .led_out(led_out),
    .mode_en(mode_en), .mode_idx(mode_idx), .busy(busy)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] en;
    logic [7:0] led;
  } exp_t;

  exp_t       exp_q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         switches = 0;
  int         blank_len = 0;
  bit         mon_en = 1'b0;
  bit         prev_busy = 1'b0;
  bit         led_pending = 1'b0;
  logic [7:0] led_exp;
  logic [7:0] lanes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  function automatic void push_exp(input logic [1:0] idx);
    exp_t e;
    e.idx = idx;
    e.en  = 4'b0001 << idx;
    e.led = lanes[idx];
    exp_q.push_back(e);
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_sw(input int target, input int budget, output int n);
    n = 0;
    while (switches < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  // Completion monitor: each end of blanking pops the scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!mon_en) begin
      prev_busy   = 1'b0;
      blank_len   = 0;
      led_pending = 1'b0;
    end else begin
      if (led_pending) begin
        chk_cnt++;
        if (led_out !== led_exp) $display("FAIL led_after_blank: got %h want %h", led_out, led_exp);
        else pass_cnt++;
        led_pending = 1'b0;
      end
      if (busy) begin
        blank_len++;
        chk_cnt++;
        if (mode_en !== 4'b0000 || led_out !== 8'h00)
          $display("FAIL blank_outputs: got en=%b led=%h want en=0000 led=00", mode_en, led_out);
        else pass_cnt++;
      end else if (prev_busy) begin
        switches++;
        chk_cnt++;
        if (blank_len !== 3) $display("FAIL blank_len: got %0d want 3", blank_len);
        else pass_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_switch: got idx=%0d want no switch", mode_idx);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++;
          if (mode_idx !== e.idx) $display("FAIL switch_idx: got %0d want %0d", mode_idx, e.idx);
          else pass_cnt++;
          chk_cnt++;
          if (mode_en !== e.en) $display("FAIL switch_en: got %b want %b", mode_en, e.en);
          else pass_cnt++;
          led_exp     = e.led;
          led_pending = 1'b1;
        end
        blank_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic test_reset();
    rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0;
    mode_led_in = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    cycles(3);
    chk_cnt++; if (mode_idx !== 2'd0) $display("FAIL rst_idx: got %0d want 0", mode_idx); else pass_cnt++;
    chk_cnt++; if (mode_en !== 4'b0001) $display("FAIL rst_en: got %b want 0001", mode_en); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (led_out !== 8'h00) $display("FAIL rst_led: got %h want 00", led_out); else pass_cnt++;
    rst = 1'b0;
    cycles(1);
    chk_cnt++; if (mode_en !== 4'b0001) $display("FAIL run_en: got %b want 0001", mode_en); else pass_cnt++;
    chk_cnt++; if (led_out !== 8'hA1) $display("FAIL run_led: got %h want a1", led_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL run_busy: got %b want 0", busy); else pass_cnt++;
    mon_en = 1'b1;
  endtask

  task automatic test_next_hold();
    int base, n;
    base = switches;
    push_exp(2'd1);
    btn_next = 1'b1;
    cycles(10);
    btn_next = 1'b0;
    wait_sw(base + 1, 40, n);
    cycles(30);
    chk_cnt++; if (switches !== base + 1) $display("FAIL hold_switches: got %0d want %0d", switches - base, 1); else pass_cnt++;
    chk_cnt++; if (mode_idx !== 2'd1) $display("FAIL hold_idx: got %0d want 1", mode_idx); else pass_cnt++;
  endtask

  task automatic test_bounce_prev();
    int base, n;
    base = switches;
    for (int i = 0; i < 4; i++) begin
      btn_next = (i % 2 == 0);
      cycles(1);
    end
    btn_next = 1'b0;
    cycles(20);
    chk_cnt++; if (switches !== base) $display("FAIL bounce_switches: got %0d want 0", switches - base); else pass_cnt++;
    push_exp(2'd0);
    btn_prev = 1'b1; cycles(8); btn_prev = 1'b0;
    wait_sw(base + 1, 40, n);
    cycles(10);
    push_exp(2'd3);
    btn_prev = 1'b1; cycles(8); btn_prev = 1'b0;
    wait_sw(base + 2, 40, n);
    cycles(10);
    chk_cnt++; if (switches !== base + 2) $display("FAIL prev_switches: got %0d want 2", switches - base); else pass_cnt++;
    chk_cnt++; if (mode_idx !== 2'd3) $display("FAIL prev_wrap_idx: got %0d want 3", mode_idx); else pass_cnt++;
  endtask

  task automatic test_auto();
    int base, n;
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    base = switches;
    for (int k = 0; k < 5; k++) push_exp(seq[k]);
    auto_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_sw(base + k + 1, 80, n);
      chk_cnt++; if (n !== 53) $display("FAIL auto_period_%0d: got %0d cycles want 53", k, n); else pass_cnt++;
    end
    auto_en = 1'b0;
    cycles(2);
    auto_en = 1'b1; cycles(30); auto_en = 1'b0; cycles(5);
    chk_cnt++; if (switches !== base + 5) $display("FAIL auto_off_switches: got %0d want 5", switches - base); else pass_cnt++;
    push_exp(2'd1);
    auto_en = 1'b1;
    wait_sw(base + 6, 80, n);
    chk_cnt++; if (n !== 53) $display("FAIL auto_restart: got %0d cycles want 53", n); else pass_cnt++;
    auto_en = 1'b0;
    cycles(3);
    chk_cnt++; if (mode_idx !== 2'd1) $display("FAIL auto_idx: got %0d want 1", mode_idx); else pass_cnt++;
  endtask

  task automatic test_arbitration();
    int base, n, m;
    base = switches;
    btn_next = 1'b1; btn_prev = 1'b1; cycles(8);
    btn_next = 1'b0; btn_prev = 1'b0; cycles(20);
    chk_cnt++; if (switches !== base) $display("FAIL both_switches: got %0d want 0", switches - base); else pass_cnt++;
    chk_cnt++; if (mode_idx !== 2'd1) $display("FAIL both_idx: got %0d want 1", mode_idx); else pass_cnt++;
    // Button pulse lands on the same cycle as the 50th-count tick
    push_exp(2'd2);
    auto_en = 1'b1;
    n = 0;
    repeat (43) begin cycles(1); n++; end
    btn_next = 1'b1;
    wait_sw(base + 1, 40, m);
    btn_next = 1'b0;
    auto_en = 1'b0;
    chk_cnt++; if (n + m !== 53) $display("FAIL coincide_time: got %0d cycles want 53", n + m); else pass_cnt++;
    cycles(15);
    chk_cnt++; if (switches !== base + 1) $display("FAIL coincide_switches: got %0d want 1", switches - base); else pass_cnt++;
    chk_cnt++; if (mode_idx !== 2'd2) $display("FAIL coincide_idx: got %0d want 2", mode_idx); else pass_cnt++;
    push_exp(2'd3);
    btn_next = 1'b1; cycles(2);
    btn_prev = 1'b1; cycles(8);
    btn_next = 1'b0; btn_prev = 1'b0;
    cycles(30);
    chk_cnt++; if (switches !== base + 2) $display("FAIL blank_press_switches: got %0d want 2", switches - base); else pass_cnt++;
    chk_cnt++; if (mode_idx !== 2'd3) $display("FAIL blank_press_idx: got %0d want 3", mode_idx); else pass_cnt++;
  endtask

  task automatic test_reset_in_blank();
    int n;
    mon_en = 1'b0;
    btn_prev = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 30) begin cycles(1); n++; end
    chk_cnt++; if (busy !== 1'b1) $display("FAIL rblank_busy: got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if (mode_idx !== 2'd2) $display("FAIL rblank_target: got %0d want 2", mode_idx); else pass_cnt++;
    rst = 1'b1; btn_prev = 1'b0;
    cycles(1);
    chk_cnt++; if (mode_idx !== 2'd0) $display("FAIL rblank_idx: got %0d want 0", mode_idx); else pass_cnt++;
    chk_cnt++; if (mode_en !== 4'b0001) $display("FAIL rblank_en: got %b want 0001", mode_en); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rblank_busy0: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (led_out !== 8'h00) $display("FAIL rblank_led: got %h want 00", led_out); else pass_cnt++;
    rst = 1'b0;
    cycles(20);
    chk_cnt++; if (mode_idx !== 2'd0) $display("FAIL post_rst_idx: got %0d want 0", mode_idx); else pass_cnt++;
    chk_cnt++; if (led_out !== 8'hA1) $display("FAIL post_rst_led: got %h want a1", led_out); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_next_hold();
    test_bounce_prev();
    test_auto();
    test_arbitration();
    test_reset_in_blank();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
